// File: rtl/sad_block_search_pkg.sv
// sad_block_search_pkg
//   Shared definitions for the block SAD search unit: candidate indices,
//   candidate count, tie-break priority, candidate enable rule and the
//   controller state type.
package sad_block_search_pkg;

    localparam int NUM_CAND  = 5;

    localparam int CAND_RQ   = 0;  // right quarter-pel
    localparam int CAND_RH   = 1;  // right half-pel
    localparam int CAND_FULL = 2;  // integer position
    localparam int CAND_LH   = 3;  // left half-pel
    localparam int CAND_LQ   = 4;  // left quarter-pel

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SELECT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Tie-break order: rank 0 wins ties. The integer position is preferred,
    // then half-pel, then quarter-pel.
    function automatic int tie_cand(input int rank);
        case (rank)
            0:       return CAND_FULL;
            1:       return CAND_RH;
            2:       return CAND_LH;
            3:       return CAND_RQ;
            default: return CAND_LQ;
        endcase
    endfunction

    // Quarter-pel candidates only take part when enabled for the block.
    function automatic logic cand_enabled(input int cand, input logic qpel_en);
        return qpel_en || ((cand != CAND_RQ) && (cand != CAND_LQ));
    endfunction

endpackage

// File: rtl/sad_block_search_if.sv
// sad_block_search_if
//   Row input stream and block result stream of sad_block_search.
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high; the producer holds valid and its data stable until then,
//   and ready may be asserted independently of valid.
//   Row side   : in_valid/in_ready, in_last, filter_pix, ref_pix, cfg_qpel_en
//   Result side: out_valid/out_ready, sad, best_idx, sad_sat, row_cnt
//   dbg_state  : controller state, observation only
//   Modports   : master = row producer / result consumer, slave = the unit.
interface sad_block_search_if #(
    parameter int PIX_W    = 8,
    parameter int NUM_PIX  = 8,
    parameter int MAX_ROWS = 16,
    parameter int SAD_W    = 16
);
    import sad_block_search_pkg::*;

    localparam int CNT_W = $clog2(MAX_ROWS + 1);

    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [NUM_PIX*PIX_W-1:0]    filter_pix;
    logic [NUM_PIX*PIX_W-1:0]    ref_pix;
    logic                        cfg_qpel_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_CAND*SAD_W-1:0]   sad;
    logic [2:0]                  best_idx;
    logic                        sad_sat;
    logic [CNT_W-1:0]            row_cnt;
    state_t                      dbg_state;

    modport master (
        output in_valid, in_last, filter_pix, ref_pix, cfg_qpel_en, out_ready,
        input  in_ready, out_valid, sad, best_idx, sad_sat, row_cnt, dbg_state
    );

    modport slave (
        input  in_valid, in_last, filter_pix, ref_pix, cfg_qpel_en, out_ready,
        output in_ready, out_valid, sad, best_idx, sad_sat, row_cnt, dbg_state
    );

endinterface

// File: rtl/abs_diff.sv
// abs_diff
//   Combinational absolute difference of two unsigned values.
//   a, b : operands (W bits)
//   d    : |a - b| (W bits)
module abs_diff #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_block_search_row_calc.sv
// sad_row_calc
//   Combinational per-row work: horizontal sub-pixel interpolation of the
//   filter row, absolute differences against the reference row and the five
//   exact candidate row sums over pixels 1..NUM_PIX-2.
//   filter_pix : filter row, pixel i at [i*PIX_W +: PIX_W]
//   ref_pix    : reference row, same packing
//   row_sum    : exact row sum per candidate
module sad_row_calc
    import sad_block_search_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 8,
    parameter int ROW_W   = PIX_W + $clog2(NUM_PIX - 1)
) (
    input  logic [NUM_PIX*PIX_W-1:0] filter_pix,
    input  logic [NUM_PIX*PIX_W-1:0] ref_pix,
    output logic [ROW_W-1:0]         row_sum [NUM_CAND]
);

    // Two extra bits hold 3*F+F without overflow at all-ones pixels.
    localparam int IW   = PIX_W + 2;
    localparam int NPOS = NUM_PIX - 2;

    // Every interpolant lies within the pixel range, so each difference
    // fits in PIX_W bits.
    logic [PIX_W-1:0] diff [NPOS][NUM_CAND];

    // Edge reference pixels are never scored.
    logic unused_ref;
    assign unused_ref = ^{ref_pix[PIX_W-1:0], ref_pix[NUM_PIX*PIX_W-1 -: PIX_W]};

    for (genvar p = 0; p < NPOS; p++) begin : g_pos
        logic [IW-1:0] f_m, f_c, f_n, r_c;
        logic [IW-1:0] cand [NUM_CAND];
        logic [IW-1:0] d    [NUM_CAND];

        assign f_m = IW'(filter_pix[p*PIX_W +: PIX_W]);
        assign f_c = IW'(filter_pix[(p+1)*PIX_W +: PIX_W]);
        assign f_n = IW'(filter_pix[(p+2)*PIX_W +: PIX_W]);
        assign r_c = IW'(ref_pix[(p+1)*PIX_W +: PIX_W]);

        assign cand[CAND_RQ]   = ((f_c << 1) + f_c + f_n) >> 2;
        assign cand[CAND_RH]   = (f_c + f_n) >> 1;
        assign cand[CAND_FULL] = f_c;
        assign cand[CAND_LH]   = (f_m + f_c) >> 1;
        assign cand[CAND_LQ]   = (f_m + (f_c << 1) + f_c) >> 2;

        for (genvar c = 0; c < NUM_CAND; c++) begin : g_cand
            logic unused_d;
            abs_diff #(.W(IW)) u_abs_diff (
                .a (cand[c]),
                .b (r_c),
                .d (d[c])
            );
            assign diff[p][c] = d[c][PIX_W-1:0];
            assign unused_d   = ^d[c][IW-1:PIX_W];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CAND; c++) begin
            row_sum[c] = '0;
            for (int p = 0; p < NPOS; p++) begin
                row_sum[c] = row_sum[c] + ROW_W'(diff[p][c]);
            end
        end
    end

endmodule

// File: rtl/sad_block_search.sv
// sad_block_search
//   Accumulates five horizontal sub-pixel candidate SADs over a block of
//   rows (one row per cycle) and reports the block SADs with the index of
//   the best candidate.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sad_block_search_if (row input, block result,
//              controller state)
//   Flow: ACCUM registers each accepted row's sums (stage 1) and folds the
//   previous stage-1 sums into the accumulators; DRAIN folds the last row;
//   SELECT registers the result; HOLD presents it until out_ready.
module sad_block_search
    import sad_block_search_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int NUM_PIX  = 8,
    parameter int MAX_ROWS = 16,
    parameter int SAD_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    sad_block_search_if.slave bus
);

    localparam int ROW_W = PIX_W + $clog2(NUM_PIX - 1);
    localparam int CNT_W = $clog2(MAX_ROWS + 1);
    // One bit wider than either operand so the raw sum never wraps.
    localparam int SUM_W = ((SAD_W > ROW_W) ? SAD_W : ROW_W) + 1;
    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    state_t                  state;
    logic [ROW_W-1:0]        row_sum  [NUM_CAND];
    logic [ROW_W-1:0]        s1_sum   [NUM_CAND];
    logic                    s1_valid;
    logic [SAD_W-1:0]        acc      [NUM_CAND];
    logic [SAD_W-1:0]        acc_add  [NUM_CAND];
    logic [SAD_W-1:0]        sad_q    [NUM_CAND];
    logic [NUM_CAND-1:0]     add_ovf;
    logic [NUM_CAND-1:0]     en_mask;
    logic [NUM_CAND*SAD_W-1:0] sad_flat;
    logic [2:0]              best_q;
    logic [2:0]              best_next;
    logic                    sat_q;
    logic                    sat_hit;
    logic                    out_valid_q;
    logic                    qpel_lat;
    logic [CNT_W-1:0]        row_cnt;
    logic                    accept;
    logic                    last_row;

    sad_row_calc #(
        .PIX_W   (PIX_W),
        .NUM_PIX (NUM_PIX),
        .ROW_W   (ROW_W)
    ) u_row_calc (
        .filter_pix (bus.filter_pix),
        .ref_pix    (bus.ref_pix),
        .row_sum    (row_sum)
    );

    assign accept   = bus.in_valid && (state == ST_ACCUM);
    // The row that fills the counter closes the block regardless of in_last.
    assign last_row = bus.in_last || (row_cnt == CNT_W'(MAX_ROWS - 1));

    // Saturating add of stage 1 into the accumulators.
    always_comb begin
        logic [SUM_W-1:0] wide;
        wide = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            wide       = SUM_W'(acc[c]) + SUM_W'(s1_sum[c]);
            add_ovf[c] = wide > SUM_W'(SAD_MAX);
            acc_add[c] = add_ovf[c] ? SAD_MAX : wide[SAD_W-1:0];
            en_mask[c] = cand_enabled(c, qpel_lat);
        end
    end

    // Disabled quarter-pel candidates never mark the block saturated.
    assign sat_hit = |(add_ovf & en_mask);

    // Minimum search in tie-priority order; only a strictly smaller value
    // displaces the current choice, so earlier ranks win ties.
    always_comb begin
        logic [SAD_W-1:0] best_val;
        int               c;
        c         = CAND_FULL;
        best_next = 3'(CAND_FULL);
        best_val  = acc[CAND_FULL];
        for (int k = 1; k < NUM_CAND; k++) begin
            c = tie_cand(k);
            if (en_mask[c] && (acc[c] < best_val)) begin
                best_next = 3'(c);
                best_val  = acc[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ACCUM;
            s1_valid    <= 1'b0;
            qpel_lat    <= 1'b0;
            row_cnt     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            best_q      <= 3'(CAND_FULL);
            for (int c = 0; c < NUM_CAND; c++) begin
                acc[c]    <= '0;
                s1_sum[c] <= '0;
                sad_q[c]  <= '0;
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (s1_valid) begin
                        acc   <= acc_add;
                        sat_q <= sat_q | sat_hit;
                    end
                    s1_valid <= accept;
                    if (accept) begin
                        s1_sum  <= row_sum;
                        row_cnt <= row_cnt + 1'b1;
                        if (row_cnt == '0) qpel_lat <= bus.cfg_qpel_en;
                        if (last_row) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (s1_valid) begin
                        acc   <= acc_add;
                        sat_q <= sat_q | sat_hit;
                    end
                    s1_valid <= 1'b0;
                    state    <= ST_SELECT;
                end
                ST_SELECT: begin
                    best_q <= best_next;
                    for (int c = 0; c < NUM_CAND; c++) begin
                        sad_q[c] <= en_mask[c] ? acc[c] : SAD_MAX;
                    end
                    out_valid_q <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        row_cnt     <= '0;
                        sat_q       <= 1'b0;
                        for (int c = 0; c < NUM_CAND; c++) acc[c] <= '0;
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        sad_flat = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            sad_flat[c*SAD_W +: SAD_W] = sad_q[c];
        end
    end

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.sad       = sad_flat;
    assign bus.best_idx  = best_q;
    assign bus.sad_sat   = sat_q;
    assign bus.row_cnt   = row_cnt;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sad_block_search.sv
// tb_sad_block_search
//   Two instances share one stimulus stream: dut_a with SAD_W=16 and dut_b
//   with SAD_W=10 (so saturation is reached easily). Expected results come
//   from a plain-arithmetic model of the candidate formulas, queued per
//   block and compared when the result is presented.
module tb_sad_block_search;

    localparam int PW  = 8;
    localparam int NP  = 8;
    localparam int MR  = 16;
    localparam int SWA = 16;
    localparam int SWB = 10;
    localparam int CW  = $clog2(MR + 1);
    localparam int WA  = 5*SWA + 3 + 1 + CW;
    localparam int WB  = 5*SWB + 3 + 1 + CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sad_block_search_if #(.PIX_W(PW), .NUM_PIX(NP), .MAX_ROWS(MR), .SAD_W(SWA)) ifa ();
    sad_block_search_if #(.PIX_W(PW), .NUM_PIX(NP), .MAX_ROWS(MR), .SAD_W(SWB)) ifb ();

    sad_block_search #(.PIX_W(PW), .NUM_PIX(NP), .MAX_ROWS(MR), .SAD_W(SWA)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    sad_block_search #(.PIX_W(PW), .NUM_PIX(NP), .MAX_ROWS(MR), .SAD_W(SWB)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [WA-1:0] exp_qa[$];
    logic [WB-1:0] exp_qb[$];
    int fpx [MR][NP];
    int rpx [MR][NP];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [127:0] expect_res(input longint tot[5], input int w,
                                                input bit q, input int n);
        longint mx;
        longint v[5];
        longint mn;
        bit     en[5];
        bit     sat;
        int     best;
        int     ord[5];
        logic [127:0] res;
        ord = '{2, 1, 3, 0, 4};
        mx  = (64'd1 << w) - 1;
        sat = 1'b0;
        res = '0;
        for (int c = 0; c < 5; c++) begin
            en[c] = q || (c >= 1 && c <= 3);
            if (!en[c]) v[c] = mx;
            else begin
                v[c] = (tot[c] > mx) ? mx : tot[c];
                if (tot[c] > mx) sat = 1'b1;
            end
        end
        mn = mx + 1;
        for (int c = 0; c < 5; c++) if (en[c] && v[c] < mn) mn = v[c];
        best = 2;
        for (int k = 4; k >= 0; k--) if (en[ord[k]] && v[ord[k]] == mn) best = ord[k];
        for (int b = 0; b < CW; b++) res[b] = n[b];
        res[CW] = sat;
        for (int b = 0; b < 3; b++) res[CW+1+b] = best[b];
        for (int c = 0; c < 5; c++)
            for (int b = 0; b < w; b++) res[CW+4+c*w+b] = v[c][b];
        return res;
    endfunction

    task automatic model_push(input int n, input bit q);
        longint tot[5];
        logic [127:0] r;
        int f0, fm, fn, rr;
        for (int c = 0; c < 5; c++) tot[c] = 0;
        for (int row = 0; row < n; row++) begin
            for (int i = 1; i <= NP-2; i++) begin
                fm = fpx[row][i-1]; f0 = fpx[row][i]; fn = fpx[row][i+1]; rr = rpx[row][i];
                tot[0] += iabs((3*f0 + fn) / 4 - rr);
                tot[1] += iabs((f0 + fn) / 2 - rr);
                tot[2] += iabs(f0 - rr);
                tot[3] += iabs((fm + f0) / 2 - rr);
                tot[4] += iabs((fm + 3*f0) / 4 - rr);
            end
        end
        r = expect_res(tot, SWA, q, n);
        exp_qa.push_back(r[WA-1:0]);
        r = expect_res(tot, SWB, q, n);
        exp_qb.push_back(r[WB-1:0]);
    endtask

    // mode: 0 random, 1 small noise, 2 flat 100, 3 ramp, 4 255 vs 0
    task automatic gen_rows(input int n, input int mode);
        int d;
        for (int row = 0; row < n; row++) begin
            for (int i = 0; i < NP; i++) begin
                case (mode)
                    0: begin fpx[row][i] = $urandom_range(0, 255); rpx[row][i] = $urandom_range(0, 255); end
                    1: begin
                        fpx[row][i] = $urandom_range(0, 255);
                        d = $urandom_range(0, 20);
                        d = fpx[row][i] + d - 10;
                        rpx[row][i] = (d < 0) ? 0 : ((d > 255) ? 255 : d);
                    end
                    2: begin fpx[row][i] = 100; rpx[row][i] = 100; end
                    3: begin fpx[row][i] = 10*i; rpx[row][i] = 10*i + 5; end
                    default: begin fpx[row][i] = 255; rpx[row][i] = 0; end
                endcase
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bus(input logic v, input logic last, input logic cfg,
                             input logic [NP*PW-1:0] fv, input logic [NP*PW-1:0] rv);
        ifa.in_valid = v;  ifb.in_valid = v;
        ifa.in_last = last; ifb.in_last = last;
        ifa.cfg_qpel_en = cfg; ifb.cfg_qpel_en = cfg;
        ifa.filter_pix = fv; ifb.filter_pix = fv;
        ifa.ref_pix = rv;    ifb.ref_pix = rv;
    endtask

    task automatic drive_row(input int row, input logic last, input logic cfg);
        logic [NP*PW-1:0] fv, rv;
        for (int i = 0; i < NP; i++) begin
            fv[i*PW +: PW] = PW'(fpx[row][i]);
            rv[i*PW +: PW] = PW'(rpx[row][i]);
        end
        drive_bus(1'b1, last, cfg, fv, rv);
        check("a_in_ready_accum", ifa.in_ready, 1);
        check("b_in_ready_accum", ifb.in_ready, 1);
        @(negedge clk);
    endtask

    task automatic idle_bus();
        drive_bus(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    // Sends a block and returns at the first cycle its result is visible.
    task automatic send_block(input int n, input int mode, input bit q,
                              input bit no_last, input bit bubbles);
        int lat;
        gen_rows(n, mode);
        model_push(n, q);
        for (int row = 0; row < n; row++) begin
            if (bubbles && row > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    idle_bus();
                    @(negedge clk);
                end
            end
            // cfg_qpel_en only matters on the first row; later rows get noise.
            drive_row(row, (row == n-1) && !no_last, (row == 0) ? q : 1'($urandom));
        end
        idle_bus();
        lat = 1;
        while (!ifa.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("result_latency", lat, 3);
        check("b_out_valid_rise", ifb.out_valid, 1);
    endtask

    task automatic finish_block(input int hold);
        logic [WA-1:0] ea;
        logic [WB-1:0] eb;
        ea = '0;
        eb = '0;
        check("exp_queue_depth", exp_qa.size(), 1);
        if (exp_qa.size() > 0) ea = exp_qa.pop_front();
        if (exp_qb.size() > 0) eb = exp_qb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            check("a_out_valid_hold", ifa.out_valid, 1);
            check("a_in_ready_hold", ifa.in_ready, 0);
            check("b_in_ready_hold", ifb.in_ready, 0);
            check("a_sad", ifa.sad, ea[WA-1:CW+4]);
            check("a_best_idx", ifa.best_idx, ea[CW+3:CW+1]);
            check("a_sad_sat", ifa.sad_sat, ea[CW]);
            check("a_row_cnt", ifa.row_cnt, ea[CW-1:0]);
            check("b_sad", ifb.sad, eb[WB-1:CW+4]);
            check("b_best_idx", ifb.best_idx, eb[CW+3:CW+1]);
            check("b_sad_sat", ifb.sad_sat, eb[CW]);
            check("b_row_cnt", ifb.row_cnt, eb[CW-1:0]);
            if (h < hold) @(negedge clk);
        end
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
        check("a_out_valid_after_take", ifa.out_valid, 0);
        check("a_in_ready_after_take", ifa.in_ready, 1);
        check("b_in_ready_after_take", ifb.in_ready, 1);
        check("a_row_cnt_after_take", ifa.row_cnt, 0);
        check("b_sad_sat_after_take", ifb.sad_sat, 0);
    endtask

    task automatic check_reset();
        check("a_rst_out_valid", ifa.out_valid, 0);
        check("a_rst_sad", ifa.sad, 0);
        check("a_rst_best_idx", ifa.best_idx, 2);
        check("a_rst_sad_sat", ifa.sad_sat, 0);
        check("a_rst_row_cnt", ifa.row_cnt, 0);
        check("a_rst_in_ready", ifa.in_ready, 1);
        check("b_rst_out_valid", ifb.out_valid, 0);
        check("b_rst_sad", ifb.sad, 0);
        check("b_rst_best_idx", ifb.best_idx, 2);
        check("b_rst_row_cnt", ifb.row_cnt, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_bus();
        ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);

        // Flat block: every candidate zero, tie resolves to the integer position.
        send_block(4, 2, 1'b1, 1'b0, 1'b0);
        check("flat_sad", ifa.sad, 0);
        check("flat_best_idx", ifa.best_idx, 2);
        check("flat_row_cnt", ifa.row_cnt, 4);
        finish_block(0);

        // Single-row ramp.
        send_block(1, 3, 1'b1, 1'b0, 1'b0);
        check("ramp_c0", ifa.sad[0*SWA +: SWA], 18);
        check("ramp_c1", ifa.sad[1*SWA +: SWA], 0);
        check("ramp_c2", ifa.sad[2*SWA +: SWA], 30);
        check("ramp_c3", ifa.sad[3*SWA +: SWA], 60);
        check("ramp_c4", ifa.sad[4*SWA +: SWA], 48);
        check("ramp_best_idx", ifa.best_idx, 1);
        finish_block(1);

        // Same ramp with quarter-pel disabled.
        send_block(1, 3, 1'b0, 1'b0, 1'b0);
        check("noq_c0", ifa.sad[0*SWA +: SWA], 16'hffff);
        check("noq_c4", ifa.sad[4*SWA +: SWA], 16'hffff);
        check("noq_b_c0", ifb.sad[0*SWB +: SWB], 10'h3ff);
        check("noq_best_idx", ifa.best_idx, 1);
        check("noq_sad_sat", ifb.sad_sat, 0);
        finish_block(0);

        // Saturation on the narrow instance.
        send_block(1, 4, 1'b1, 1'b0, 1'b0);
        check("sat_b_c2", ifb.sad[2*SWB +: SWB], 1023);
        check("sat_b_flag", ifb.sad_sat, 1);
        check("sat_a_c2", ifa.sad[2*SWA +: SWA], 1530);
        check("sat_a_flag", ifa.sad_sat, 0);
        finish_block(0);

        // Backpressure: result held for 5 extra cycles.
        send_block(3, 0, 1'b1, 1'b0, 1'b1);
        finish_block(5);

        // Row limit: no in_last, block closes at MAX_ROWS.
        send_block(MR, 1, 1'b1, 1'b1, 1'b0);
        check("limit_row_cnt", ifa.row_cnt, MR);
        finish_block(0);

        // Reset in the middle of a block discards it.
        gen_rows(2, 0);
        drive_row(0, 1'b0, 1'b1);
        drive_row(1, 1'b0, 1'b1);
        idle_bus();
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);
        send_block(1, 2, 1'b1, 1'b0, 1'b0);
        check("post_rst_row_cnt", ifa.row_cnt, 1);
        check("post_rst_sad", ifa.sad, 0);
        finish_block(0);

        // Randomized blocks.
        repeat (40) begin
            send_block($urandom_range(1, 6), $urandom_range(0, 1), 1'($urandom), 1'b0, 1'b1);
            finish_block($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
